// File: rtl/temperature_calculator_if.sv
// Conversion request/result bundle between the ADC front end and the
// temperature calculator.
interface temperature_calculator_if;
  logic        start;
  logic [31:0] tc_base;
  logic [7:0]  tc_ref;
  logic [15:0] adc_data;
  logic [31:0] tempc;
  logic        busy;
  logic        done;

  modport master (
    output start, tc_base, tc_ref, adc_data,
    input  tempc, busy, done
  );

  modport slave (
    input  start, tc_base, tc_ref, adc_data,
    output tempc, busy, done
  );
endinterface

// File: rtl/temperature_calculator.sv
// temperature_calculator: tempc = adc * tc_base + tc_ref.
// adc is sign-magnitude; the 15-bit magnitude is multiplied by shift-add
// over 15 cycles, then the sign and reference offset are applied in one
// finishing cycle. All arithmetic wraps modulo 2^32.
module temperature_calculator (
  input  logic                           clk,
  input  logic                           rst,
  temperature_calculator_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [7:0]  ref_q, ref_d;
  logic [15:0] adc_q, adc_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] tempc_q, tempc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] signed_prod;

  // State and datapath registers; reset clears everything including operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      ref_q   <= '0;
      adc_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      tempc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ref_q   <= ref_d;
      adc_q   <= adc_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tempc_q <= tempc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, shift-add step and result formation.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    ref_d       = ref_q;
    adc_d       = adc_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tempc_d     = tempc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    signed_prod = adc_q[15] ? (32'd0 - acc_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.tc_base;
          ref_d   = bus.tc_ref;
          adc_d   = bus.adc_data;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        if (adc_q[cnt_q]) begin
          acc_d = acc_q + (base_q << cnt_q);
        end
        if (cnt_q == 4'd14) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FIN: begin
        tempc_d = signed_prod + {{24{ref_q[7]}}, ref_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.tempc = tempc_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_temperature_calculator.sv
// Scoreboard bench for temperature_calculator.
module tb_temperature_calculator;

  logic clk;
  logic rst;
  int unsigned errors;
  int unsigned checks;
  logic [31:0] exp_q[$];
  logic        prev_done;

  temperature_calculator_if bus ();

  temperature_calculator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] b, input logic [7:0] r,
                                        input logic [15:0] a);
    logic [31:0] p;
    p = b * {17'd0, a[14:0]};
    if (a[15]) p = -p;
    return p + {{24{r[7]}}, r};
  endfunction

  // Output side of the scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("done_unexpected", {31'd0, bus.done}, 32'd0);
      end else begin
        check("tempc", bus.tempc, exp_q.pop_front());
      end
    end
    prev_done = rst ? 1'b0 : bus.done;
  end

  task automatic run_conv(input logic [31:0] b, input logic [7:0] r,
                          input logic [15:0] a, input bit disturb);
    int unsigned n;
    logic [31:0] e;
    e = model(b, r, a);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.tc_base  = b;
    bus.tc_ref   = r;
    bus.adc_data = a;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.tc_base  = $urandom;
    bus.tc_ref   = 8'($urandom);
    bus.adc_data = 16'($urandom);
    check("busy_rise", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (!bus.done && n < 40) begin
      if (disturb && n == 5) begin
        bus.start    = 1'b1;
        bus.tc_base  = $urandom;
        bus.tc_ref   = 8'($urandom);
        bus.adc_data = 16'($urandom);
      end else if (disturb && n == 6) begin
        bus.start = 1'b0;
      end else if (disturb && n == 15) begin
        bus.start = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check("latency", n, 32'd16);
    check("busy_fall", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    check("done_fall", {31'd0, bus.done}, 32'd0);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("tempc_hold", bus.tempc, e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    errors       = 0;
    checks       = 0;
    prev_done    = 1'b0;
    bus.start    = 1'b0;
    bus.tc_base  = '0;
    bus.tc_ref   = '0;
    bus.adc_data = '0;
    rst          = 1'b1;
    #2;
    check("rst_tempc", bus.tempc, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_conv(32'd100, 8'd40, 16'h8009, 1'b0);
    run_conv(32'd100, 8'd40, 16'h0009, 1'b0);
    run_conv(32'd100, 8'hD8, 16'h8009, 1'b0);
    run_conv(32'hFFFFFF9C, 8'd40, 16'h0009, 1'b0);
    run_conv(32'h7FFFFFFF, 8'd0, 16'h7FFF, 1'b0);
    run_conv(32'h12345678, 8'd40, 16'h8000, 1'b0);
    run_conv(32'd250, 8'h81, 16'h0123, 1'b1);

    // Reset in the middle of MUL aborts the conversion with no done.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.tc_base  = 32'd77;
    bus.tc_ref   = 8'd5;
    bus.adc_data = 16'h0055;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tempc", bus.tempc, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    run_conv(32'd100, 8'd40, 16'h0009, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_conv($urandom, 8'($urandom), 16'($urandom), 1'(i % 2));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
